// File: rtl/ra_2r1w_32x32_bist.sv
// ---------------------------------------------------------------------------
// ra_2r1w_32x32_bist
//
// Built-in self test engine for a 32-entry x 32-bit register array with two
// read ports and one write port. A test runs two phases. Each phase writes
// the whole array with an alternating background pattern and then reads it
// back through both read ports at once. Port 0 walks the addresses upwards
// and port 1 walks them downwards.
//
// Parameters
//   RD_LAT       cycles from a read request to valid read data
//                (2 = latched read data, 1 = unlatched)
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse that begins a test (ignored unless idle)
//   bg           background pattern, sampled on the start cycle
//   ra_rd_enb_*  read enables for read ports 0 and 1
//   ra_rd_adr_*  read addresses for read ports 0 and 1
//   ra_wr_*      write enable, address and data for the write port
//   ra_rd_dat_*  read data returned by the array wrapper
//   busy         high from the first write up to the end of the last drain
//   done         one-cycle pulse at the end of a completed test
//   fail         sticky mismatch flag, cleared by the next start
//   err_cnt      saturating count of mismatching port reads
//   err_adr      read step (port-0 address) of the first mismatch
//   err_port     port of the first mismatch (port 0 wins a tie)
// ---------------------------------------------------------------------------
module ra_2r1w_32x32_bist #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [0:31] bg,
  output logic        ra_rd_enb_0,
  output logic [0:4]  ra_rd_adr_0,
  output logic        ra_rd_enb_1,
  output logic [0:4]  ra_rd_adr_1,
  output logic        ra_wr_enb_0,
  output logic [0:4]  ra_wr_adr_0,
  output logic [0:31] ra_wr_dat_0,
  input  logic [0:31] ra_rd_dat_0,
  input  logic [0:31] ra_rd_dat_1,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [0:7]  err_cnt,
  output logic [0:4]  err_adr,
  output logic        err_port
);

  typedef enum logic [3:0] {
    IDLE, WR0, GAP0, RD0, DRN0, WR1, GAP1, RD1, DRN1, DONE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] adr0;
    logic [4:0] adr1;
    logic       ph;
  } cmp_t;

  localparam logic [4:0] DRN_LAST = 5'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bg_q, bg_d;
  logic        launch;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        phase_q, phase_d;
  logic        wr_enb_q, wr_enb_d;
  logic [4:0]  wr_adr_q, wr_adr_d;
  logic [31:0] wr_dat_q, wr_dat_d;
  logic        rd_enb_q, rd_enb_d;
  logic [4:0]  rd_adr0_q, rd_adr0_d;
  logic [4:0]  rd_adr1_q, rd_adr1_d;

  cmp_t        pipe_q [RD_LAT];
  cmp_t        head;
  logic        mis0, mis1;
  logic [8:0]  err_sum;

  logic        fail_q, fail_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [4:0]  err_adr_q, err_adr_d;
  logic        err_port_q, err_port_d;

  // Even addresses hold B and odd addresses hold ~B in phase 0. Phase 1
  // swaps the two.
  function automatic logic [31:0] exp_data(input logic [4:0] a, input logic ph,
                                           input logic [31:0] b);
    return (a[0] ^ ph) ? ~b : b;
  endfunction

  // Next-state logic. The address counter is 5 bits wide, so the step after
  // address 31 wraps to 0. That wrap is what ends each write and read phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bg_d    = bg_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR0;
          cnt_d   = '0;
          bg_d    = bg;
          launch  = 1'b1;
        end
      end
      WR0, WR1, RD0, RD1: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          if (state_q == WR0)      state_d = GAP0;
          else if (state_q == WR1) state_d = GAP1;
          else if (state_q == RD0) state_d = DRN0;
          else                     state_d = DRN1;
        end
      end
      GAP0: begin
        state_d = RD0;
        cnt_d   = '0;
      end
      GAP1: begin
        state_d = RD1;
        cnt_d   = '0;
      end
      DRN0, DRN1: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DRN_LAST) begin
          state_d = (state_q == DRN0) ? WR1 : DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so that the registered
    // versions line up with the state register.
    phase_d   = state_d inside {WR1, GAP1, RD1, DRN1};
    wr_enb_d  = state_d inside {WR0, WR1};
    rd_enb_d  = state_d inside {RD0, RD1};
    wr_adr_d  = wr_enb_d ? cnt_d : '0;
    wr_dat_d  = wr_enb_d ? exp_data(cnt_d, phase_d, bg_d) : '0;
    rd_adr0_d = rd_enb_d ? cnt_d : '0;
    rd_adr1_d = rd_enb_d ? ~cnt_d : '0;
    busy_d    = !(state_d inside {IDLE, DONE});
    done_d    = (state_d == DONE);
  end

  // Result checking. The tail of the pipeline describes the read whose data
  // is on ra_rd_dat_* in this cycle. err_adr records the read step, which is
  // also the port-0 address. The port-1 address for that step is
  // 31 - err_adr.
  always_comb begin
    head       = pipe_q[RD_LAT-1];
    mis0       = head.valid && (ra_rd_dat_0 != exp_data(head.adr0, head.ph, bg_q));
    mis1       = head.valid && (ra_rd_dat_1 != exp_data(head.adr1, head.ph, bg_q));
    err_sum    = {1'b0, err_cnt_q} + {8'd0, mis0} + {8'd0, mis1};
    fail_d     = fail_q;
    err_cnt_d  = err_cnt_q;
    err_adr_d  = err_adr_q;
    err_port_d = err_port_q;
    if (launch) begin
      fail_d     = 1'b0;
      err_cnt_d  = '0;
      err_adr_d  = '0;
      err_port_d = 1'b0;
    end else if (mis0 || mis1) begin
      fail_d    = 1'b1;
      err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
      if (!fail_q) begin
        err_adr_d  = head.adr0;
        err_port_d = !mis0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bg_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      phase_q    <= 1'b0;
      wr_enb_q   <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= '0;
      rd_enb_q   <= 1'b0;
      rd_adr0_q  <= '0;
      rd_adr1_q  <= '0;
      fail_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_adr_q  <= '0;
      err_port_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bg_q       <= bg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      phase_q    <= phase_d;
      wr_enb_q   <= wr_enb_d;
      wr_adr_q   <= wr_adr_d;
      wr_dat_q   <= wr_dat_d;
      rd_enb_q   <= rd_enb_d;
      rd_adr0_q  <= rd_adr0_d;
      rd_adr1_q  <= rd_adr1_d;
      fail_q     <= fail_d;
      err_cnt_q  <= err_cnt_d;
      err_adr_q  <= err_adr_d;
      err_port_q <= err_port_d;
      pipe_q[0]  <= cmp_t'{valid: rd_enb_q, adr0: rd_adr0_q, adr1: rd_adr1_q, ph: phase_q};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign ra_rd_enb_0 = rd_enb_q;
  assign ra_rd_adr_0 = rd_adr0_q;
  assign ra_rd_enb_1 = rd_enb_q;
  assign ra_rd_adr_1 = rd_adr1_q;
  assign ra_wr_enb_0 = wr_enb_q;
  assign ra_wr_adr_0 = wr_adr_q;
  assign ra_wr_dat_0 = wr_dat_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign err_cnt     = err_cnt_q;
  assign err_adr     = err_adr_q;
  assign err_port    = err_port_q;

endmodule

// File: tb/tb_ra_2r1w_32x32_bist.sv
// ---------------------------------------------------------------------------
// tb_ra_2r1w_32x32_bist
//
// Drives two BIST instances. The first uses RD_LAT=2 and sits behind a
// latched 2R1W memory model that can inject faults. The second uses
// RD_LAT=1 and sits behind an unlatched, fault-free model. The expected
// end-of-test results come from a behavioural reference model of the memory
// plus its fault. The expected per-cycle request stream comes from the
// documented state timing.
// ---------------------------------------------------------------------------
module tb_ra_2r1w_32x32_bist;

  localparam int LAT      = 2;
  localparam int DONE_CYC = 130 + 2 * LAT;
  localparam int MAX_WAIT = 400;
  localparam logic [31:0] BIT5 = 32'h0400_0000;

  typedef struct packed {
    logic [15:0] doneCyc;
    logic        fail;
    logic [7:0]  errCnt;
    logic [4:0]  errAdr;
    logic        errPort;
  } result_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wrEnb;
    logic [4:0]  wrAdr;
    logic [31:0] wrDat;
    logic        rdEnb0;
    logic [4:0]  rdAdr0;
    logic        rdEnb1;
    logic [4:0]  rdAdr1;
  } req_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic [0:31] bg = '0;
  int   faultMode = 0;
  logic memClear = 1'b0;

  logic        rdEnb0, rdEnb1, wrEnb, busy, done, fail, errPort;
  logic [0:4]  rdAdr0, rdAdr1, wrAdr, errAdr;
  logic [0:31] wrDat, rdDat0, rdDat1;
  logic [0:7]  errCnt;

  logic        u1RdEnb0, u1RdEnb1, u1WrEnb, u1Busy, u1Done, u1Fail, u1ErrPort;
  logic [0:4]  u1RdAdr0, u1RdAdr1, u1WrAdr, u1ErrAdr;
  logic [0:31] u1WrDat, u1RdDat0, u1RdDat1;
  logic [0:7]  u1ErrCnt;

  result_t expQ[$];
  req_t    reqQ[$];
  int      checks = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  ra_2r1w_32x32_bist #(.RD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bg(bg),
    .ra_rd_enb_0(rdEnb0), .ra_rd_adr_0(rdAdr0),
    .ra_rd_enb_1(rdEnb1), .ra_rd_adr_1(rdAdr1),
    .ra_wr_enb_0(wrEnb), .ra_wr_adr_0(wrAdr), .ra_wr_dat_0(wrDat),
    .ra_rd_dat_0(rdDat0), .ra_rd_dat_1(rdDat1),
    .busy(busy), .done(done), .fail(fail),
    .err_cnt(errCnt), .err_adr(errAdr), .err_port(errPort)
  );

  ra_2r1w_32x32_bist #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .bg(bg),
    .ra_rd_enb_0(u1RdEnb0), .ra_rd_adr_0(u1RdAdr0),
    .ra_rd_enb_1(u1RdEnb1), .ra_rd_adr_1(u1RdAdr1),
    .ra_wr_enb_0(u1WrEnb), .ra_wr_adr_0(u1WrAdr), .ra_wr_dat_0(u1WrDat),
    .ra_rd_dat_0(u1RdDat0), .ra_rd_dat_1(u1RdDat1),
    .busy(u1Busy), .done(u1Done), .fail(u1Fail),
    .err_cnt(u1ErrCnt), .err_adr(u1ErrAdr), .err_port(u1ErrPort)
  );

  // Latched memory model for the RD_LAT=2 instance.
  // Fault modes: 1 = port-0 data bit 5 stuck at 1, 2 = both read ports
  // stuck at zero, 3 = write address bit 4 stuck at 0.
  logic [0:31] mem0 [32];
  logic [0:31] q0a, q0b, l0a, l0b;
  logic [0:4]  wrAdrEff;
  assign wrAdrEff = (faultMode == 3) ? {wrAdr[0:3], 1'b0} : wrAdr;

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 32; i++) mem0[i] <= '0;
    end else if (wrEnb) begin
      mem0[wrAdrEff] <= wrDat;
    end
    q0a <= mem0[rdAdr0];
    q0b <= mem0[rdAdr1];
    l0a <= q0a;
    l0b <= q0b;
  end

  assign rdDat0 = (faultMode == 2) ? '0 : ((faultMode == 1) ? (l0a | BIT5) : l0a);
  assign rdDat1 = (faultMode == 2) ? '0 : l0b;

  // Unlatched, fault-free memory model for the RD_LAT=1 instance.
  logic [0:31] mem1 [32];
  logic [0:31] q1a, q1b;

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 32; i++) mem1[i] <= '0;
    end else if (u1WrEnb) begin
      mem1[u1WrAdr] <= u1WrDat;
    end
    q1a <= mem1[u1RdAdr0];
    q1b <= mem1[u1RdAdr1];
  end

  assign u1RdDat0 = q1a;
  assign u1RdDat1 = q1b;

  function automatic logic [31:0] expPat(input int a, input int ph, input logic [31:0] b);
    return ((a % 2) != ph) ? ~b : b;
  endfunction

  // Reference model: runs both phases against a cleared, possibly faulty
  // memory and accumulates what the engine is expected to report.
  function automatic result_t predict(input logic [31:0] b, input int mode, input int lat);
    result_t     r;
    logic [31:0] m [32];
    logic [31:0] d0, d1;
    int          cnt;
    int          wa;
    bit          bad0, bad1;
    r = '0;
    cnt = 0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 32; a++) begin
        wa = (mode == 3) ? (a & 30) : a;
        m[wa] = expPat(a, ph, b);
      end
      for (int s = 0; s < 32; s++) begin
        d0 = m[s];
        d1 = m[31 - s];
        if (mode == 1) d0 = d0 | BIT5;
        if (mode == 2) begin
          d0 = '0;
          d1 = '0;
        end
        bad0 = (d0 != expPat(s, ph, b));
        bad1 = (d1 != expPat(31 - s, ph, b));
        if ((bad0 || bad1) && !r.fail) begin
          r.errAdr  = 5'(s);
          r.errPort = !bad0;
        end
        if (bad0 || bad1) r.fail = 1'b1;
        cnt = cnt + int'(bad0) + int'(bad1);
        if (cnt > 255) cnt = 255;
      end
    end
    r.errCnt  = 8'(cnt);
    r.doneCyc = 16'(130 + 2 * lat);
    return r;
  endfunction

  // Request outputs expected k cycles after the start edge.
  function automatic req_t reqAt(input int k, input logic [31:0] b);
    req_t r;
    int   w1, r0, r1, dn;
    r  = '0;
    r0 = 33;
    w1 = 65 + LAT;
    r1 = w1 + 33;
    dn = r1 + 32 + LAT;
    r.busy = (k < dn);
    r.done = (k == dn);
    if (k < 32) begin
      r.wrEnb = 1'b1; r.wrAdr = 5'(k); r.wrDat = expPat(k, 0, b);
    end else if (k >= r0 && k < r0 + 32) begin
      r.rdEnb0 = 1'b1; r.rdEnb1 = 1'b1; r.rdAdr0 = 5'(k - r0); r.rdAdr1 = 5'(31 - (k - r0));
    end else if (k >= w1 && k < w1 + 32) begin
      r.wrEnb = 1'b1; r.wrAdr = 5'(k - w1); r.wrDat = expPat(k - w1, 1, b);
    end else if (k >= r1 && k < r1 + 32) begin
      r.rdEnb0 = 1'b1; r.rdEnb1 = 1'b1; r.rdAdr0 = 5'(k - r1); r.rdAdr1 = 5'(31 - (k - r1));
    end
    return r;
  endfunction

  function automatic result_t sampleResult(input int cyc);
    result_t r;
    r.doneCyc = 16'(cyc);
    r.fail    = fail;
    r.errCnt  = errCnt;
    r.errAdr  = errAdr;
    r.errPort = errPort;
    return r;
  endfunction

  function automatic string fmtResult(input result_t r);
    return $sformatf("done@%0d fail=%0b cnt=%0d adr=%0d port=%0b",
                     r.doneCyc, r.fail, r.errCnt, r.errAdr, r.errPort);
  endfunction

  // Clears the memory models, pulses start with the given background and
  // pushes the predicted result. Returns at the first sample point after
  // the start edge (cycle 0). bg is then changed to prove it was latched.
  task automatic applyStimulus(input logic [31:0] b, input int mode);
    @(negedge clk);
    faultMode = mode;
    memClear  = 1'b1;
    @(negedge clk);
    memClear = 1'b0;
    bg       = b;
    start    = 1'b1;
    expQ.push_back(predict(b, mode, LAT));
    @(negedge clk);
    start = 1'b0;
    bg    = ~b;
  endtask

  task automatic waitDone(output int cyc);
    cyc = -1;
    for (int k = 0; k < MAX_WAIT; k++) begin
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, fail, errCnt, errAdr, errPort} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_status: got %h, expected 0", {busy, done, fail, errCnt, errAdr, errPort});
    end
    checks++;
    if ({rdEnb0, rdEnb1, wrEnb, rdAdr0, rdAdr1, wrAdr, wrDat} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_requests: got %h, expected 0", {rdEnb0, rdEnb1, wrEnb, rdAdr0, rdAdr1, wrAdr, wrDat});
    end
    checks++;
    if ({u1RdEnb0, u1RdEnb1, u1WrEnb, u1RdAdr0, u1RdAdr1, u1WrAdr, u1WrDat, u1Busy, u1Done,
         u1Fail, u1ErrCnt, u1ErrAdr, u1ErrPort} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_lat1: got %h, expected 0",
               {u1RdEnb0, u1RdEnb1, u1WrEnb, u1RdAdr0, u1RdAdr1, u1WrAdr, u1WrDat, u1Busy,
                u1Done, u1Fail, u1ErrCnt, u1ErrAdr, u1ErrPort});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, wrEnb, rdEnb0} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got %b, expected 0000", {busy, done, wrEnb, rdEnb0});
    end
  endtask

  task automatic test_sequence();
    logic [31:0] b;
    req_t        obs, exp;
    result_t     resObs, resExp;
    int          firstDone, shown;
    b = 32'hA5C3_0F12;
    for (int k = 0; k <= DONE_CYC + 1; k++) reqQ.push_back(reqAt(k, b));
    applyStimulus(b, 0);
    firstDone = -1;
    shown = 0;
    resObs = '1;
    for (int k = 0; k <= DONE_CYC + 1; k++) begin
      obs = '{busy: busy, done: done, wrEnb: wrEnb, wrAdr: wrAdr, wrDat: wrDat,
              rdEnb0: rdEnb0, rdAdr0: rdAdr0, rdEnb1: rdEnb1, rdAdr1: rdAdr1};
      exp = reqQ.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        if (shown < 4) begin
          shown++;
          $display("[TB] FAIL request_stream cycle %0d: got %h, expected %h", k, obs, exp);
        end
      end
      if (done === 1'b1 && firstDone < 0) begin
        firstDone = k;
        resObs = sampleResult(k);
      end
      @(negedge clk);
    end
    resExp = expQ.pop_front();
    checks++;
    if (resObs !== resExp) begin
      failures++;
      $display("[TB] FAIL sequence_result: got %s, expected %s", fmtResult(resObs), fmtResult(resExp));
    end
  endtask

  task automatic test_ideal();
    result_t obs, exp;
    int      cyc;
    applyStimulus(32'h0, 0);
    waitDone(cyc);
    obs = sampleResult(cyc);
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL ideal_bg0: got %s, expected %s", fmtResult(obs), fmtResult(exp));
    end
  endtask

  task automatic test_stuck_port0();
    result_t obs, exp;
    int      cyc;
    applyStimulus(32'h0, 1);
    waitDone(cyc);
    obs = sampleResult(cyc);
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL stuck_bit5_port0: got %s, expected %s", fmtResult(obs), fmtResult(exp));
    end
  endtask

  task automatic test_stuck_zero();
    result_t obs, exp;
    int      cyc;
    applyStimulus(32'h0, 2);
    waitDone(cyc);
    obs = sampleResult(cyc);
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL stuck_zero_both: got %s, expected %s", fmtResult(obs), fmtResult(exp));
    end
  endtask

  task automatic test_busy_restart();
    result_t obs, exp;
    int      firstDone, firstFail;
    logic    lateBusy;
    applyStimulus(32'hFFFF_0000, 3);
    firstDone = -1;
    firstFail = -1;
    lateBusy  = 1'b0;
    obs       = '1;
    for (int k = 0; k <= DONE_CYC + 2; k++) begin
      if (fail === 1'b1 && firstFail < 0) firstFail = k;
      if (done === 1'b1 && firstDone < 0) begin
        firstDone = k;
        obs = sampleResult(k);
      end
      if (k > DONE_CYC && busy !== 1'b0) lateBusy = 1'b1;
      start = (k == 20 || k == DONE_CYC);
      @(negedge clk);
    end
    start = 1'b0;
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL wradr_fault_result: got %s, expected %s", fmtResult(obs), fmtResult(exp));
    end
    checks++;
    if (firstFail != 33 + LAT + 1) begin
      failures++;
      $display("[TB] FAIL first_fail_cycle: got %0d, expected %0d", firstFail, 33 + LAT + 1);
    end
    checks++;
    if (lateBusy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_in_done_ignored: got busy after done, expected idle");
    end
  endtask

  task automatic test_reset_mid();
    result_t obs, exp;
    int      cyc;
    logic    sawActive;
    applyStimulus(32'h0, 1);
    repeat (50) @(negedge clk);
    checks++;
    if (fail !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fail_before_abort: got %b, expected 1", fail);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, fail, errCnt, errAdr, errPort, rdEnb0, rdEnb1, wrEnb, rdAdr0, rdAdr1,
         wrAdr, wrDat} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_outputs: got %h, expected 0",
               {busy, done, fail, errCnt, errAdr, errPort, rdEnb0, rdEnb1, wrEnb, rdAdr0,
                rdAdr1, wrAdr, wrDat});
    end
    void'(expQ.pop_front());
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sawActive = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) sawActive = 1'b1;
    end
    checks++;
    if (sawActive !== 1'b0 || {fail, errCnt} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got active=%b fail=%b cnt=%0d, expected 0 0 0",
               sawActive, fail, errCnt);
    end
    applyStimulus(32'h0, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL first_start_after_reset: got busy=%b, expected 1", busy);
    end
    waitDone(cyc);
    obs = sampleResult(cyc);
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL restart_result: got %s, expected %s", fmtResult(obs), fmtResult(exp));
    end
  endtask

  task automatic test_lat1();
    result_t obs, exp;
    int      cyc;
    @(negedge clk);
    faultMode = 0;
    memClear  = 1'b1;
    @(negedge clk);
    memClear = 1'b0;
    bg       = 32'h1234_5678;
    start1   = 1'b1;
    expQ.push_back(predict(32'h1234_5678, 0, 1));
    @(negedge clk);
    start1 = 1'b0;
    cyc = -1;
    for (int k = 0; k < MAX_WAIT; k++) begin
      if (u1Done === 1'b1) begin
        cyc = k;
        break;
      end
      @(negedge clk);
    end
    obs = '{doneCyc: 16'(cyc), fail: u1Fail, errCnt: u1ErrCnt, errAdr: u1ErrAdr, errPort: u1ErrPort};
    exp = expQ.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL lat1_result: got %s, expected %s", fmtResult(obs), fmtResult(exp));
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_sequence();
    test_ideal();
    test_stuck_port0();
    test_stuck_zero();
    test_busy_restart();
    test_reset_mid();
    test_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ra_2r1w_32x32_bist.md
RA_2R1W_32X32_BIST -- requirements
Module: ra_2r1w_32x32_bist

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: cycles from read request to valid read data (2 = latched read data, 1 = unlatched).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: a one-cycle pulse that begins a test.
REQ-006 SHALL have port bg, input, [0:31]: background pattern B, sampled on the start cycle.
REQ-007 SHALL have ports ra_rd_enb_0/ra_rd_adr_0[0:4] and ra_rd_enb_1/ra_rd_adr_1[0:4], outputs: read requests to the array wrapper.
REQ-008 SHALL have ports ra_wr_enb_0/ra_wr_adr_0[0:4]/ra_wr_dat_0[0:31], outputs: the write request.
REQ-009 SHALL have ports ra_rd_dat_0[0:31] and ra_rd_dat_1[0:31], inputs: read data from the wrapper.
REQ-010 SHALL have outputs busy (1), done (1) and fail (1).
REQ-011 SHALL have outputs err_cnt[0:7], err_adr[0:4] and err_port (1).
REQ-012 SHALL drive every output from a flop.

Function
REQ-013 Expected data: E(a,ph) = B for even a and ~B for odd a when ph=0; the inverse when ph=1.
REQ-014 SHALL implement states IDLE, WR0, GAP0, RD0, DRN0, WR1, GAP1, RD1, DRN1, DONE.
REQ-015 IDLE -> WR0 on start; SHALL latch B and clear fail, err_cnt, err_adr and err_port.
REQ-016 WRn (n = phase) SHALL run 32 cycles, one per address a = 0..31 ascending: wr_enb=1, wr_adr=a, wr_dat=E(a,n).
REQ-017 GAPn SHALL last 1 cycle with all enables 0, so no write precedes a read of the same address.
REQ-018 RDn SHALL run 32 cycles, step a = 0..31: port 0 reads a and port 1 reads 31-a, both enables 1.
REQ-019 DRNn SHALL last RD_LAT cycles with enables 0; then DRN0 -> WR1 and DRN1 -> DONE.
REQ-020 DONE SHALL pulse done for 1 cycle, then return to IDLE.
REQ-021 Total busy time SHALL be 130+2*RD_LAT cycles (134 at default); busy=1 in every state except IDLE and DONE.
REQ-022 Compare pipeline: a RD_LAT-deep shift register SHALL carry (valid, port-0 address, port-1 address, phase) for each read cycle.
REQ-023 Compare: in each cycle where the pipeline output is valid, ra_rd_dat_0 SHALL be checked against E(adr0,ph) and ra_rd_dat_1 against E(adr1,ph).
REQ-024 A mismatch on either port SHALL set fail (sticky until next start).
REQ-025 err_cnt SHALL add the number of mismatching ports that cycle (0, 1 or 2) and saturate at 255.
REQ-026 First mismatch only SHALL capture err_adr and err_port; if both ports fail in the same cycle, port 0 takes priority (err_port=0).
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 Address counter SHALL be 5 bits; the wrap from 31 to 0 is the phase-exit condition, not an error.
REQ-029 Outside RDn/WRn all enables SHALL be 0; addresses and write data SHALL be 0.

Reset
REQ-030 reset_n low SHALL immediately force IDLE and clear all outputs, counters, the pipeline and latched B to 0.
REQ-031 Reset mid-test SHALL abort with no done pulse; fail and err_cnt read 0 after release.
REQ-032 The first start after reset_n deasserts SHALL be honoured in the next cycle.

Verification
REQ-033 Ideal 2R1W memory model, bg=0, RD_LAT=2, start -> done pulses 134 cycles after start; fail=0; err_cnt=0.
REQ-034 Same setup but ra_rd_dat_0 bit 5 stuck at 1 -> fail=1, err_cnt=32, err_adr=0, err_port=0; port 1 contributes no errors.
REQ-035 Both read ports stuck at all-zero, bg=0 -> err_cnt=64; first error err_adr=0, err_port=1 (port 1 reads addr 31, odd, expects ones).
REQ-036 Write-port address bit 4 stuck at 0, bg=32'hFFFF0000 -> fail=1 with first error in RD0; pulse start during busy -> no restart; done still at cycle 134.
REQ-037 Assert reset_n low at cycle 50 of a test -> all outputs 0 immediately; a restart completes in 134 cycles with a clean result.
REQ-038 RD_LAT=1 with unlatched memory model -> done at cycle 132, fail=0.
